// File: rtl/rr16_arbiter_pkg.sv
// Shared definitions for the 16-way round-robin arbiter.
// Holds the FSM encodings and the reset value of the priority pointer.
package rr16_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] PTR_RST = 4'hF;

endpackage

// File: rtl/b16to1_muxer.sv
// 16-to-1 single-bit multiplexer steered by the arbiter's mux command.
// Purely combinational.
module b16to1_muxer (
    input  logic [15:0] x15_x0,
    input  logic [3:0]  b3_b0,
    output logic        y
);

    assign y = x15_x0[b3_b0];

endmodule

// File: rtl/rr16_arbiter_prio_enc.sv
// Rotated priority search over 16 request lines, starting at start and wrapping.
// Purely combinational; found is low when no line is requesting.
module rr16_prio_enc (
    input  logic [15:0] rq15_rq0,
    input  logic [3:0]  start,
    output logic [3:0]  winner,
    output logic        found
);

    logic [3:0] idx;

    // Scanning from the far end lets the nearest request overwrite, so no early exit is needed.
    always_comb begin
        winner = 4'h0;
        found  = 1'b0;
        idx    = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            idx = start + 4'(i);
            if (rq15_rq0[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr16_arbiter.sv
// Round-robin arbiter that grants one of 16 requesters the mux and bounds each hold to MAX_HOLD cycles.
// Grant appears one cycle after request; release by done, dropped request or timeout hands off with no bubble.
module rr16_arbiter
    import rr16_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] rq15_rq0,
    input  logic        done,
    output logic [3:0]  b3_b0,
    output logic [15:0] gnt15_gnt0,
    output logic        valid
);

    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

    state_t          state, state_nxt;
    logic [3:0]      ptr, ptr_nxt;
    logic [3:0]      sel, sel_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [15:0]     gnt, gnt_nxt;
    logic [3:0]      start;
    logic [3:0]      winner;
    logic            found;
    logic            release_grant;

    // While granted ptr equals sel, so searching from sel+1 leaves the holder eligible last.
    assign start = (state == ST_GRANT) ? sel + 4'h1 : ptr + 4'h1;

    rr16_prio_enc u_prio_enc (
        .rq15_rq0 (rq15_rq0),
        .start    (start),
        .winner   (winner),
        .found    (found)
    );

    assign release_grant = done | ~rq15_rq0[sel] | (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nxt = ST_GRANT;
                    sel_nxt   = winner;
                    ptr_nxt   = winner;
                    cnt_nxt   = '0;
                    gnt_nxt   = 16'h0001 << winner;
                end
            end
            ST_GRANT: begin
                if (!release_grant) begin
                    cnt_nxt = cnt + CW'(1);
                end else if (found) begin
                    sel_nxt = winner;
                    ptr_nxt = winner;
                    cnt_nxt = '0;
                    gnt_nxt = 16'h0001 << winner;
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    gnt_nxt   = 16'h0000;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= PTR_RST;
            sel   <= 4'h0;
            cnt   <= '0;
            gnt   <= 16'h0000;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
        end
    end

    assign valid      = (state == ST_GRANT);
    assign b3_b0      = sel;
    assign gnt15_gnt0 = gnt;

endmodule

// File: tb/tb_rr16_arbiter.sv
// Directed bench for rr16_arbiter steering a b16to1_muxer.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.
module tb_rr16_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] rq15_rq0;
    logic        done;
    logic [3:0]  b3_b0;
    logic [15:0] gnt15_gnt0;
    logic        valid;
    logic [15:0] x15_x0;
    logic        y;

    int total = 0;
    int bad   = 0;

    rr16_arbiter #(.MAX_HOLD(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .rq15_rq0   (rq15_rq0),
        .done       (done),
        .b3_b0      (b3_b0),
        .gnt15_gnt0 (gnt15_gnt0),
        .valid      (valid)
    );

    b16to1_muxer u_mux (
        .x15_x0 (x15_x0),
        .b3_b0  (b3_b0),
        .y      (y)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rq15_rq0 = 16'h0000;
        done     = 1'b0;
        step();
        reset    = 1'b0;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] idx);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_b"}, 32'(b3_b0), 32'(idx));
        chk({tag, "_gnt"}, 32'(gnt15_gnt0), 32'(16'h0001 << idx));
    endtask

    initial begin
        x15_x0 = 16'h0020;
        do_reset();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_gnt", 32'(gnt15_gnt0), 32'h0);
        chk("rst_b", 32'(b3_b0), 32'h0);

        // single requester and data path
        rq15_rq0 = 16'h0020;
        step();
        chk_grant("single", 4'd5);
        chk("mux_hi", 32'(y), 32'd1);
        x15_x0 = 16'hFFDF;
        #1;
        chk("mux_lo", 32'(y), 32'd0);
        rq15_rq0 = 16'h0000;
        step();
        chk("single_rel_valid", 32'(valid), 32'd0);
        chk("single_rel_gnt", 32'(gnt15_gnt0), 32'h0);
        chk("single_rel_b", 32'(b3_b0), 32'd5);

        // wrap-around with done on every grant cycle
        do_reset();
        rq15_rq0 = 16'h8001;
        done     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_grant("wrap", (k % 2 == 0) ? 4'd0 : 4'd15);
        end
        done = 1'b0;

        // timeout alternation between 3 and 7
        do_reset();
        rq15_rq0 = 16'h0088;
        for (int k = 0; k < 17; k++) begin
            step();
            chk("to_b", 32'(b3_b0), (k >= 8 && k < 16) ? 32'd7 : 32'd3);
            chk("to_valid", 32'(valid), 32'd1);
        end

        // sole requester re-granted on timeout and on done
        do_reset();
        rq15_rq0 = 16'h0004;
        for (int k = 0; k < 18; k++) begin
            step();
            chk_grant("sole", 4'd2);
            chk("sole_cnt", 32'(dut.cnt), 32'(k % 8));
        end
        done = 1'b1;
        step();
        done = 1'b0;
        chk_grant("sole_done", 4'd2);
        chk("sole_done_cnt", 32'(dut.cnt), 32'd0);

        // request drop and re-request
        do_reset();
        rq15_rq0 = 16'h0200;
        step();
        chk_grant("drop", 4'd9);
        rq15_rq0 = 16'h0000;
        step();
        chk("drop_valid", 32'(valid), 32'd0);
        chk("drop_gnt", 32'(gnt15_gnt0), 32'h0);
        rq15_rq0 = 16'h0200;
        step();
        chk_grant("drop_again", 4'd9);

        // asynchronous reset while granting 12
        do_reset();
        rq15_rq0 = 16'h1000;
        step();
        chk_grant("pre_rst", 4'd12);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_gnt", 32'(gnt15_gnt0), 32'h0);
        chk("arst_b", 32'(b3_b0), 32'h0);
        #1;
        reset    = 1'b0;
        rq15_rq0 = 16'hFFFF;
        step();
        chk_grant("post_rst", 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
